// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the fetch PC, issues one outstanding imem read at a time,
// buffers returned words in a small prefetch FIFO and hands them to the decoder.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       word;
  } fentry_t;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t            state;
  fentry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rptr, wptr;
  logic [CNT_W-1:0]  count, post_cnt;
  logic [ADDR_W-1:0] fetch_pc, pc_inc;
  logic              push, pop;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  // A redirect kills the returning word even when it lands the same edge.
  assign push        = (state == REQ) & imem_ack & ~redirect;
  assign post_cnt    = count + CNT_W'(push) - CNT_W'(pop);
  assign pc_inc      = fetch_pc + ADDR_W'(1);
  assign instr       = instr_valid ? mem[rptr].word : '0;
  assign instr_pc    = instr_valid ? mem[rptr].pc   : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{pc: fetch_pc, word: imem_rdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (redirect) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      count <= post_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (fetch_en && count < DEPTH) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            if (imem_ack) begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end else begin
              state <= DISCARD;
            end
          end else if (imem_ack) begin
            fetch_pc <= pc_inc;
            // Back-to-back issue only if the slot for the next word is still free.
            if (fetch_en && post_cnt < DEPTH) begin
              imem_addr <= pc_inc;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector tables plus hand-written
// reset/discard sequences against a simple ack-delay memory model.
module tb_instr_fetch_unit;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en, imem_req, imem_ack, redirect, instr_valid, instr_ready;
  logic [AW-1:0] imem_addr, redirect_pc, instr_pc;
  logic [31:0]   imem_rdata, instr;

  logic ack_en, force_ack;
  int   ack_delay, wcnt, pops;
  int   n_chk, n_fail;

  instr_fetch_unit #(.ADDR_W(AW), .FIFO_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // Memory model: word at address a is 0x8000_0001 + a, acked after ack_delay waiting cycles.
  always @(posedge clk or posedge rst) begin
    if (rst)                       wcnt <= 0;
    else if (imem_req && imem_ack) wcnt <= 0;
    else if (imem_req)             wcnt <= wcnt + 1;
  end
  assign imem_ack   = force_ack | (ack_en & imem_req & (wcnt >= ack_delay));
  assign imem_rdata = 32'h8000_0001 + {16'h0, imem_addr};

  always @(posedge clk) begin
    if (!rst && instr_valid && instr_ready) pops <= pops + 1;
  end

  typedef struct {
    logic          fen, rdy, redir;
    logic [AW-1:0] rpc;
    logic          aen;
    logic          ereq;
    logic [AW-1:0] eaddr;
    logic          evld;
    logic [AW-1:0] epc;
  } vec_t;
  vec_t tbl[$];

  function automatic void v(logic fen, logic rdy, logic redir, logic [AW-1:0] rpc, logic aen,
                            logic ereq, logic [AW-1:0] eaddr, logic evld, logic [AW-1:0] epc);
    vec_t r;
    r = '{fen, rdy, redir, rpc, aen, ereq, eaddr, evld, epc};
    tbl.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_tbl(input string name);
    logic [31:0] ei;
    foreach (tbl[i]) begin
      fetch_en    = tbl[i].fen;
      instr_ready = tbl[i].rdy;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      ack_en      = tbl[i].aen;
      @(posedge clk); #1;
      ei = tbl[i].evld ? 32'h8000_0001 + 32'(tbl[i].epc) : 32'h0;
      chk($sformatf("%s[%0d] req", name, i), 32'(imem_req), 32'(tbl[i].ereq));
      if (tbl[i].ereq) chk($sformatf("%s[%0d] addr", name, i), 32'(imem_addr), 32'(tbl[i].eaddr));
      chk($sformatf("%s[%0d] valid", name, i), 32'(instr_valid), 32'(tbl[i].evld));
      chk($sformatf("%s[%0d] instr_pc", name, i), 32'(instr_pc),
          tbl[i].evld ? 32'(tbl[i].epc) : 32'h0);
      chk($sformatf("%s[%0d] instr", name, i), instr, ei);
    end
    tbl.delete();
    redirect = 1'b0;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; ack_en = 1'b1; force_ack = 1'b0;
    @(posedge clk); #1;
    chk({name, " rst req"}, 32'(imem_req), 32'h0);
    chk({name, " rst addr"}, 32'(imem_addr), 32'h0);
    chk({name, " rst valid"}, 32'(instr_valid), 32'h0);
    chk({name, " rst instr"}, instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    n_chk = 0; n_fail = 0; pops = 0; ack_delay = 0;
    rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; ack_en = 1'b1; force_ack = 1'b0;

    // 1: same-cycle ack, streaming back-to-back
    do_reset("t1"); ack_delay = 0;
    v(1,1,0,0,1, 1,16'h0,0,0);
    v(1,1,0,0,1, 1,16'h1,1,16'h0);
    v(1,1,0,0,1, 1,16'h2,1,16'h1);
    v(1,1,0,0,1, 1,16'h3,1,16'h2);
    v(1,1,0,0,1, 1,16'h4,1,16'h3);
    run_tbl("t1");

    // 2: decoder stalled fills FIFO to 4, then drains in order and refetch at 4
    do_reset("t2"); ack_delay = 0;
    v(1,0,0,0,1, 1,16'h0,0,0);
    v(1,0,0,0,1, 1,16'h1,1,16'h0);
    v(1,0,0,0,1, 1,16'h2,1,16'h0);
    v(1,0,0,0,1, 1,16'h3,1,16'h0);
    v(1,0,0,0,1, 0,16'h0,1,16'h0);
    v(1,0,0,0,1, 0,16'h0,1,16'h0);
    v(1,1,0,0,1, 0,16'h0,1,16'h1);
    v(1,1,0,0,1, 1,16'h4,1,16'h2);
    v(1,1,0,0,1, 1,16'h5,1,16'h3);
    v(1,1,0,0,1, 1,16'h6,1,16'h4);
    run_tbl("t2");

    // 3: slow memory, request held stable, output gated while empty
    do_reset("t3"); ack_delay = 3;
    v(1,1,0,0,1, 1,16'h0,0,0);
    v(1,1,0,0,1, 1,16'h0,0,0);
    v(1,1,0,0,1, 1,16'h0,0,0);
    v(1,1,0,0,1, 1,16'h0,0,0);
    v(1,1,0,0,1, 1,16'h1,1,16'h0);
    run_tbl("t3");

    // 4: redirect while request to 5 is pending -> DISCARD, refetch from 0x40
    do_reset("t4"); ack_delay = 0;
    v(1,1,0,0,1, 1,16'h0,0,0);
    v(1,1,0,0,1, 1,16'h1,1,16'h0);
    v(1,1,0,0,1, 1,16'h2,1,16'h1);
    v(1,1,0,0,1, 1,16'h3,1,16'h2);
    v(1,1,0,0,1, 1,16'h4,1,16'h3);
    v(1,1,0,0,1, 1,16'h5,1,16'h4);
    v(1,1,1,16'h40,0, 1,16'h5,0,0);
    v(1,1,0,0,0, 1,16'h5,0,0);
    v(1,1,0,0,1, 0,16'h0,0,0);
    v(1,1,0,0,1, 1,16'h40,0,0);
    v(1,1,0,0,1, 1,16'h41,1,16'h40);
    run_tbl("t4");

    // 5: redirect on the same edge as ack and pop
    do_reset("t5"); ack_delay = 0; p0 = pops;
    v(1,1,0,0,1, 1,16'h0,0,0);
    v(1,1,0,0,1, 1,16'h1,1,16'h0);
    v(1,1,0,0,1, 1,16'h2,1,16'h1);
    v(1,1,1,16'h100,1, 0,16'h0,0,0);
    v(1,1,0,0,1, 1,16'h100,0,0);
    v(1,1,0,0,1, 1,16'h101,1,16'h100);
    run_tbl("t5");
    chk("t5 pop count", 32'(pops - p0), 32'd2);

    // 6: PC wrap at 0xFFFF, then async reset mid-request
    do_reset("t6"); ack_delay = 0;
    v(0,1,1,16'hFFFF,1, 0,16'h0,0,0);
    v(1,1,0,0,1, 1,16'hFFFF,0,0);
    v(1,1,0,0,1, 1,16'h0000,1,16'hFFFF);
    v(1,1,0,0,0, 1,16'h0000,0,0);
    run_tbl("t6");
    #2 rst = 1'b1;
    #1;
    chk("t6 midrst req", 32'(imem_req), 32'h0);
    chk("t6 midrst valid", 32'(instr_valid), 32'h0);
    chk("t6 midrst instr", instr, 32'h0);
    chk("t6 midrst addr", 32'(imem_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0; fetch_en = 1'b0; ack_en = 1'b1; force_ack = 1'b1;
    @(posedge clk); #1;
    chk("t6 stray ack valid", 32'(instr_valid), 32'h0);
    chk("t6 stray ack req", 32'(imem_req), 32'h0);
    force_ack = 1'b0; fetch_en = 1'b1;
    @(posedge clk); #1;
    chk("t6 restart req", 32'(imem_req), 32'h1);
    chk("t6 restart addr", 32'(imem_addr), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
